// File: rtl/ma_axis_multich.sv
// Multi-channel signed boxcar moving average on a time-interleaved AXI-Stream.
// Each channel keeps its own circular history, write pointer and running sum.
// The output is registered, giving one cycle of latency at full throughput.
module ma_axis_multich #(
   parameter int WORD_LENGTH = 35,
   parameter int LOG2_LEN    = 2,
   parameter int NUM_CH      = 1,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          clr,
   input  logic signed [WORD_LENGTH-1:0] s_ma_tdata,
   input  logic                          s_ma_tvalid,
   input  logic                          s_ma_tlast,
   output logic                          s_ma_tready,
   output logic signed [WORD_LENGTH-1:0] m_ma_tdata,
   output logic                          m_ma_tvalid,
   output logic                          m_ma_tlast,
   output logic [CH_W-1:0]               m_ma_tchan,
   input  logic                          m_ma_tready,
   output logic                          tlast_err
);

   localparam int N  = 2 ** LOG2_LEN;
   localparam int SW = WORD_LENGTH + LOG2_LEN;
   // Pointer is at least one bit wide so a window of one still has a legal type.
   localparam int PW = (LOG2_LEN > 0) ? LOG2_LEN : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [PW-1:0]   LAST_WP = PW'(N - 1);

   logic signed [WORD_LENGTH-1:0] hist [NUM_CH][N];
   logic [PW-1:0]                 wp   [NUM_CH];
   logic signed [SW-1:0]          sum  [NUM_CH];
   logic [CH_W-1:0]               chan_cnt;

   logic                          accept;
   logic [PW-1:0]                 wp_cur;
   logic [PW-1:0]                 wp_next;
   logic signed [SW-1:0]          new_sum;
   logic signed [WORD_LENGTH-1:0] avg;
   logic                          at_last_ch;
   logic                          err_next;
   logic [CH_W-1:0]               chan_next;

   // No skid buffer: ready only when the output register is free or draining.
   assign s_ma_tready = en & ~rst & ~clr & (~m_ma_tvalid | m_ma_tready);
   assign accept      = s_ma_tvalid & s_ma_tready;

   // Datapath for the channel currently addressed by chan_cnt.
   always_comb begin
      wp_cur     = wp[chan_cnt];
      wp_next    = (wp_cur == LAST_WP) ? '0 : wp_cur + PW'(1);
      new_sum    = sum[chan_cnt] + SW'(s_ma_tdata) - SW'(hist[chan_cnt][wp_cur]);
      // Arithmetic shift gives floor rounding; the quotient always fits the word.
      avg        = WORD_LENGTH'(new_sum >>> LOG2_LEN);
      at_last_ch = (chan_cnt == LAST_CH);
      // Early tlast or missing tlast: tlast must coincide with the last channel.
      err_next   = s_ma_tlast ^ at_last_ch;
      chan_next  = (s_ma_tlast || at_last_ch) ? '0 : chan_cnt + CH_W'(1);
   end

   // History, sums, channel counter and output register.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sum[c] <= '0;
            wp[c]  <= '0;
            for (int k = 0; k < N; k++) begin
               hist[c][k] <= '0;
            end
         end
         chan_cnt  <= '0;
         tlast_err <= 1'b0;
         // clr keeps an output beat that is still waiting for the sink.
         if (rst || !m_ma_tvalid || m_ma_tready) begin
            m_ma_tvalid <= 1'b0;
            m_ma_tdata  <= '0;
            m_ma_tlast  <= 1'b0;
            m_ma_tchan  <= '0;
         end
      end else begin
         tlast_err <= 1'b0;
         if (accept) begin
            sum[chan_cnt]          <= new_sum;
            hist[chan_cnt][wp_cur] <= s_ma_tdata;
            wp[chan_cnt]           <= wp_next;
            chan_cnt               <= chan_next;
            tlast_err              <= err_next;
            m_ma_tvalid            <= 1'b1;
            m_ma_tdata             <= avg;
            m_ma_tlast             <= s_ma_tlast;
            m_ma_tchan             <= chan_cnt;
         end else if (m_ma_tready) begin
            m_ma_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ma_axis_multich.sv
// Bench for ma_axis_multich: one single-channel and one two-channel instance,
// a window-based reference model, a per-cycle compare process and
// hand-computed expectations for the delivered output streams.
module tb_ma_axis_multich;

   localparam int WL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst     [2];
   logic                 en      [2];
   logic                 clr     [2];
   logic signed [WL-1:0] s_data  [2];
   logic                 s_valid [2];
   logic                 s_last  [2];
   logic                 s_ready [2];
   logic signed [WL-1:0] m_data  [2];
   logic                 m_valid [2];
   logic                 m_last  [2];
   logic [0:0]           m_chan  [2];
   logic                 m_ready [2];
   logic                 err     [2];

   ma_axis_multich #(.WORD_LENGTH(WL), .LOG2_LEN(2), .NUM_CH(1)) u_one (
      .clk(clk), .rst(rst[0]), .en(en[0]), .clr(clr[0]),
      .s_ma_tdata(s_data[0]), .s_ma_tvalid(s_valid[0]), .s_ma_tlast(s_last[0]),
      .s_ma_tready(s_ready[0]), .m_ma_tdata(m_data[0]), .m_ma_tvalid(m_valid[0]),
      .m_ma_tlast(m_last[0]), .m_ma_tchan(m_chan[0]), .m_ma_tready(m_ready[0]),
      .tlast_err(err[0])
   );

   ma_axis_multich #(.WORD_LENGTH(WL), .LOG2_LEN(2), .NUM_CH(2)) u_two (
      .clk(clk), .rst(rst[1]), .en(en[1]), .clr(clr[1]),
      .s_ma_tdata(s_data[1]), .s_ma_tvalid(s_valid[1]), .s_ma_tlast(s_last[1]),
      .s_ma_tready(s_ready[1]), .m_ma_tdata(m_data[1]), .m_ma_tvalid(m_valid[1]),
      .m_ma_tlast(m_last[1]), .m_ma_tchan(m_chan[1]), .m_ma_tready(m_ready[1]),
      .tlast_err(err[1])
   );

   int total = 0;
   int bad   = 0;
   bit armed = 0;

   // Reference model state: last four samples per channel, oldest first.
   int win [2][2][4];
   bit mv  [2];
   int md  [2];
   bit ml  [2];
   int mc  [2];
   bit me  [2];
   int cnt [2];

   int log_d  [2][$];
   int log_c  [2][$];
   int errcnt [2];
   int exp_d  [$];
   int exp_c  [$];

   function automatic int nch(int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic int floor_div(int s, int n);
      int q;
      q = s / n;
      if ((s % n != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic bit exp_ready(int i);
      return en[i] && !rst[i] && !clr[i] && (!mv[i] || m_ready[i]);
   endfunction

   task automatic chk(string name, int act, int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
      end
   endtask

   task automatic clear_window(int i);
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 4; k++) win[i][c][k] = 0;
   endtask

   // Advance the model by one clock edge from the inputs present at that edge.
   task automatic model_step(int i);
      bit acc;
      int ch;
      int s;
      acc = s_valid[i] && exp_ready(i);
      if (rst[i] || clr[i]) begin
         clear_window(i);
         cnt[i] = 0;
         me[i]  = 0;
         if (rst[i] || !mv[i] || m_ready[i]) begin
            mv[i] = 0; md[i] = 0; ml[i] = 0; mc[i] = 0;
         end
      end else begin
         me[i] = 0;
         if (acc) begin
            ch = cnt[i];
            for (int k = 0; k < 3; k++) win[i][ch][k] = win[i][ch][k + 1];
            win[i][ch][3] = int'(s_data[i]);
            s = 0;
            for (int k = 0; k < 4; k++) s += win[i][ch][k];
            md[i] = floor_div(s, 4);
            mv[i] = 1;
            ml[i] = s_last[i];
            mc[i] = ch;
            me[i] = (s_last[i] && ch != nch(i) - 1) || (!s_last[i] && ch == nch(i) - 1);
            cnt[i] = (s_last[i] || ch == nch(i) - 1) ? 0 : ch + 1;
         end else if (m_ready[i]) begin
            mv[i] = 0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         clear_window(i);
         mv[i] = 0; md[i] = 0; ml[i] = 0; mc[i] = 0; me[i] = 0; cnt[i] = 0;
         errcnt[i] = 0;
      end
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("u%0d tready", i), int'(s_ready[i]), int'(exp_ready(i)));
               chk($sformatf("u%0d tvalid", i), int'(m_valid[i]), int'(mv[i]));
               chk($sformatf("u%0d tlast_err", i), int'(err[i]), int'(me[i]));
               if (mv[i]) begin
                  chk($sformatf("u%0d tdata", i), int'(m_data[i]), md[i]);
                  chk($sformatf("u%0d tlast", i), int'(m_last[i]), int'(ml[i]));
                  chk($sformatf("u%0d tchan", i), int'(m_chan[i]), mc[i]);
               end
               if (m_valid[i] && m_ready[i]) begin
                  log_d[i].push_back(int'(m_data[i]));
                  log_c[i].push_back(int'(m_chan[i]));
               end
               if (err[i]) errcnt[i]++;
            end
         end
      end
   end

   task automatic wait_cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until it is accepted (bounded).
   task automatic send(int i, int d, bit last);
      bit rdy;
      int n;
      s_data[i]  = WL'(d);
      s_last[i]  = last;
      s_valid[i] = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         rdy = s_ready[i];
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 50) begin
            total++;
            bad++;
            $display("FAIL u%0d accept timeout: got no accept want accept", i);
            break;
         end
      end
   endtask

   task automatic idle(int i);
      s_valid[i] = 1'b0;
      s_last[i]  = 1'b0;
   endtask

   task automatic pulse_clr(int i);
      clr[i] = 1'b1;
      wait_cyc(1);
      clr[i] = 1'b0;
   endtask

   task automatic flush(int i);
      log_d[i].delete();
      log_c[i].delete();
   endtask

   task automatic check_data(int i, string name);
      chk({name, " count"}, log_d[i].size(), exp_d.size());
      for (int k = 0; k < exp_d.size() && k < log_d[i].size(); k++)
         chk($sformatf("%s beat%0d", name, k), log_d[i][k], exp_d[k]);
   endtask

   task automatic check_chan(int i, string name);
      for (int k = 0; k < exp_c.size() && k < log_c[i].size(); k++)
         chk($sformatf("%s chan%0d", name, k), log_c[i][k], exp_c[k]);
   endtask

   task automatic check_reset_state(int i, string name);
      chk({name, " tvalid"}, int'(m_valid[i]), 0);
      chk({name, " tdata"}, int'(m_data[i]), 0);
      chk({name, " tlast"}, int'(m_last[i]), 0);
      chk({name, " tchan"}, int'(m_chan[i]), 0);
      chk({name, " tlast_err"}, int'(err[i]), 0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; en[i] = 1'b1; clr[i] = 1'b0;
         s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; m_ready[i] = 1'b1;
      end
      @(posedge clk);
      armed = 1;
      wait_cyc(1);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      check_reset_state(0, "u0 reset");
      check_reset_state(1, "u1 reset");
      wait_cyc(1);

      // Single channel, constant +100: ramps up over the window, then holds.
      flush(0);
      for (int k = 0; k < 6; k++) send(0, 100, 1'b1);
      idle(0);
      wait_cyc(3);
      exp_d = '{25, 50, 75, 100, 100, 100};
      check_data(0, "ramp");

      // Negative inputs round toward minus infinity.
      flush(0);
      pulse_clr(0);
      send(0, -4, 1'b1);
      send(0, -3, 1'b1);
      idle(0);
      wait_cyc(3);
      exp_d = '{-1, -2};
      check_data(0, "floor");

      // clr wipes history; the following +100 averages against zeros again.
      flush(0);
      pulse_clr(0);
      for (int k = 0; k < 3; k++) send(0, 100, 1'b1);
      idle(0);
      pulse_clr(0);
      send(0, 100, 1'b1);
      idle(0);
      wait_cyc(3);
      exp_d = '{25, 50, 75, 25};
      check_data(0, "clr");

      // rst mid-stream: outputs drop, history restarts.
      flush(0);
      send(0, 100, 1'b1);
      send(0, 100, 1'b1);
      idle(0);
      rst[0] = 1'b1;
      wait_cyc(1);
      rst[0] = 1'b0;
      @(negedge clk);
      check_reset_state(0, "u0 midreset");
      wait_cyc(1);
      send(0, 100, 1'b1);
      idle(0);
      wait_cyc(3);
      exp_d = '{50, 75, 25};
      check_data(0, "rst");
      chk("u0 no tlast_err", errcnt[0], 0);

      // Two interleaved channels with opposite signs.
      flush(1);
      pulse_clr(1);
      for (int f = 0; f < 4; f++) begin
         send(1, 8, 1'b0);
         send(1, -8, 1'b1);
      end
      idle(1);
      wait_cyc(3);
      exp_d = '{2, -2, 4, -4, 6, -6, 8, -8};
      exp_c = '{0, 1, 0, 1, 0, 1, 0, 1};
      check_data(1, "interleave");
      check_chan(1, "interleave");

      // Downstream stall mid-stream: nothing lost or duplicated.
      flush(1);
      pulse_clr(1);
      fork
         begin
            for (int f = 0; f < 4; f++) begin
               send(1, 40, 1'b0);
               send(1, 4, 1'b1);
            end
         end
         begin
            wait_cyc(3);
            m_ready[1] = 1'b0;
            wait_cyc(2);
            @(negedge clk);
            chk("stall tvalid", int'(m_valid[1]), 1);
            chk("stall tready", int'(s_ready[1]), 0);
            wait_cyc(3);
            m_ready[1] = 1'b1;
         end
      join
      idle(1);
      wait_cyc(3);
      exp_d = '{10, 1, 20, 2, 30, 3, 40, 4};
      exp_c = '{0, 1, 0, 1, 0, 1, 0, 1};
      check_data(1, "stall");
      check_chan(1, "stall");

      // Early tlast on ch0, then missing tlast on ch1.
      flush(1);
      pulse_clr(1);
      errcnt[1] = 0;
      send(1, 4, 1'b1);
      send(1, 4, 1'b0);
      send(1, 4, 1'b0);
      send(1, 4, 1'b0);
      send(1, 4, 1'b1);
      idle(1);
      wait_cyc(3);
      exp_d = '{1, 2, 1, 3, 2};
      exp_c = '{0, 0, 1, 0, 1};
      check_data(1, "tlast_err");
      check_chan(1, "tlast_err");
      chk("tlast_err pulses", errcnt[1], 2);

      armed = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
